i2c_req_arbiter: RTL and testbench

//  Shares one i2c_top master between NREQ requesters using round-robin arbitration.

---
 rtl/i2c_arb_pkg.sv | 15 +
 rtl/i2c_req_arbiter_rr.sv | 31 +++
 rtl/i2c_req_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_i2c_req_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_arb_pkg.sv
// Shared types and widths for the I2C requester arbiter: FSM state encoding
// and the address/byte/count field widths seen on the requester ports.
package i2c_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      RECOVER
   } state_t;

   localparam int ADDR_W = 7;
   localparam int BYTE_W = 8;
   localparam int NB_W   = 4;

endpackage

// File: rtl/i2c_req_arbiter_rr.sv
// Combinational round-robin picker: the first request found after ptr_i,
// wrapping modulo NREQ, wins. Returns a one-hot grant and its index.
module rr_arbiter #(
   parameter int NREQ  = 4,
   parameter int IDX_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [NREQ-1:0]  gnt_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             valid_o
);

   logic [IDX_W-1:0] cand;

   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      cand    = '0;
      for (int i = 1; i <= NREQ; i++) begin
         cand = IDX_W'((int'(ptr_i) + i) % NREQ);
         if (!valid_o && req_i[cand]) begin
            valid_o     = 1'b1;
            gnt_o[cand] = 1'b1;
            idx_o       = cand;
         end
      end
   end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Shares one I2C master between NREQ requesters: round-robin grant, command
// latch, per-byte steering, and a forced master reset after every transaction.
module i2c_req_arbiter
   import i2c_arb_pkg::*;
#(
   parameter int NREQ        = 4,
   parameter int RST_CYC     = 4,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic                     clk,
   input  logic                     resetN,
   input  logic [NREQ-1:0]          req,
   input  logic [ADDR_W*NREQ-1:0]   req_addr,
   input  logic [NREQ-1:0]          req_rw,
   input  logic [NB_W*NREQ-1:0]     req_nbyte,
   input  logic [BYTE_W*NREQ-1:0]   req_wdata,
   output logic [NREQ-1:0]          gnt,
   output logic [NREQ-1:0]          wr_next,
   output logic [NREQ-1:0]          rd_valid,
   output logic [BYTE_W-1:0]        rd_data,
   output logic [NREQ-1:0]          done,
   output logic [NREQ-1:0]          err,
   output logic                     busy,
   output logic                     mst_en,
   output logic                     mst_resetN,
   output logic [ADDR_W-1:0]        mst_address,
   output logic                     mst_rw,
   output logic [NB_W-1:0]          mst_N_byte,
   output logic [BYTE_W-1:0]        mst_data_in,
   input  logic [BYTE_W-1:0]        mst_data_out,
   input  logic                     mst_byte_stb,
   input  logic                     mst_done
);

   localparam int IDX_W = $clog2(NREQ);
   localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
   localparam int RC_W  = $clog2(RST_CYC + 1);

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    ptr_q, ptr_d;
   logic [NREQ-1:0]     gnt_q, gnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                rw_q, rw_d;
   logic [NB_W-1:0]     nbyte_q, nbyte_d;
   logic [NB_W-1:0]     bytes_q, bytes_d;
   logic [TO_W-1:0]     tcnt_q, tcnt_d;
   logic [RC_W-1:0]     rcnt_q, rcnt_d;
   logic [NREQ-1:0]     wr_next_q, wr_next_d;
   logic [NREQ-1:0]     rd_valid_q, rd_valid_d;
   logic [BYTE_W-1:0]   rd_data_q, rd_data_d;
   logic [NREQ-1:0]     done_q, done_d;
   logic [NREQ-1:0]     err_q, err_d;
   logic                mst_resetN_q, mst_resetN_d;

   logic [NREQ-1:0]     arb_gnt;
   logic [IDX_W-1:0]    arb_idx;
   logic                arb_valid;

   rr_arbiter #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_rr (
      .req_i   (req),
      .ptr_i   (ptr_q),
      .gnt_o   (arb_gnt),
      .idx_o   (arb_idx),
      .valid_o (arb_valid)
   );

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      gnt_d        = gnt_q;
      addr_d       = addr_q;
      rw_d         = rw_q;
      nbyte_d      = nbyte_q;
      bytes_d      = bytes_q;
      tcnt_d       = tcnt_q;
      rcnt_d       = rcnt_q;
      wr_next_d    = '0;
      rd_valid_d   = '0;
      rd_data_d    = rd_data_q;
      done_d       = '0;
      err_d        = '0;
      case (state_q)
         IDLE: begin
            if (arb_valid) begin
               state_d = RUN;
               ptr_d   = arb_idx;
               gnt_d   = arb_gnt;
               bytes_d = '0;
               tcnt_d  = '0;
               for (int i = 0; i < NREQ; i++) begin
                  if (arb_gnt[i]) begin
                     addr_d  = req_addr[i*ADDR_W +: ADDR_W];
                     rw_d    = req_rw[i];
                     nbyte_d = req_nbyte[i*NB_W +: NB_W];
                  end
               end
            end
         end
         RUN: begin
            // Strobes beyond the programmed byte count are swallowed silently.
            if (mst_byte_stb && (bytes_q < nbyte_q)) begin
               bytes_d = bytes_q + 1'b1;
               if (rw_q) begin
                  rd_valid_d = gnt_q;
                  rd_data_d  = mst_data_out;
               end else begin
                  wr_next_d = gnt_q;
               end
            end
            if (mst_byte_stb || mst_done) begin
               tcnt_d = '0;
            end else if (tcnt_q != TO_W'(TIMEOUT_CYC)) begin
               tcnt_d = tcnt_q + 1'b1;
            end
            if (mst_done) begin
               state_d = RECOVER;
               rcnt_d  = '0;
               done_d  = gnt_q;
            end else if (!mst_byte_stb && (tcnt_q >= TO_W'(TIMEOUT_CYC - 1))) begin
               state_d = RECOVER;
               rcnt_d  = '0;
               err_d   = gnt_q;
            end
         end
         RECOVER: begin
            if (rcnt_q == RC_W'(RST_CYC - 1)) begin
               state_d = IDLE;
            end else begin
               rcnt_d = rcnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      // Registered so the master stays in reset exactly for the RECOVER cycles.
      mst_resetN_d = (state_d != RECOVER);
   end

   always_ff @(posedge clk) begin
      if (!resetN) begin
         state_q      <= IDLE;
         ptr_q        <= IDX_W'(NREQ - 1);
         gnt_q        <= '0;
         addr_q       <= '0;
         rw_q         <= 1'b0;
         nbyte_q      <= '0;
         bytes_q      <= '0;
         tcnt_q       <= '0;
         rcnt_q       <= '0;
         wr_next_q    <= '0;
         rd_valid_q   <= '0;
         rd_data_q    <= '0;
         done_q       <= '0;
         err_q        <= '0;
         mst_resetN_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         gnt_q        <= gnt_d;
         addr_q       <= addr_d;
         rw_q         <= rw_d;
         nbyte_q      <= nbyte_d;
         bytes_q      <= bytes_d;
         tcnt_q       <= tcnt_d;
         rcnt_q       <= rcnt_d;
         wr_next_q    <= wr_next_d;
         rd_valid_q   <= rd_valid_d;
         rd_data_q    <= rd_data_d;
         done_q       <= done_d;
         err_q        <= err_d;
         mst_resetN_q <= mst_resetN_d;
      end
   end

   assign gnt         = (state_q == RUN) ? gnt_q : '0;
   assign mst_en      = (state_q == RUN);
   assign busy        = (state_q != IDLE);
   assign mst_resetN  = mst_resetN_q;
   assign mst_address = addr_q;
   assign mst_rw      = rw_q;
   assign mst_N_byte  = nbyte_q;
   assign wr_next     = wr_next_q;
   assign rd_valid    = rd_valid_q;
   assign rd_data     = rd_data_q;
   assign done        = done_q;
   assign err         = err_q;

   always_comb begin
      mst_data_in = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            mst_data_in = req_wdata[i*BYTE_W +: BYTE_W];
         end
      end
   end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed bench for i2c_req_arbiter: the bench plays the master stub by
// hand and compares outputs against hand-computed values.
module tb_i2c_req_arbiter;

   localparam int NREQ = 4;
   localparam int RSTC = 4;
   localparam int TOC  = 100;

   logic          clk = 1'b0;
   logic          resetN;
   logic [3:0]    req;
   logic [27:0]   req_addr;
   logic [3:0]    req_rw;
   logic [15:0]   req_nbyte;
   logic [31:0]   req_wdata;
   logic [3:0]    gnt, wr_next, rd_valid, done, err;
   logic [7:0]    rd_data;
   logic          busy, mst_en, mst_resetN, mst_rw;
   logic [6:0]    mst_address;
   logic [3:0]    mst_N_byte;
   logic [7:0]    mst_data_in, mst_data_out;
   logic          mst_byte_stb, mst_done;

   int errCount   = 0;
   int checkCount = 0;

   i2c_req_arbiter #(
      .NREQ        (NREQ),
      .RST_CYC     (RSTC),
      .TIMEOUT_CYC (TOC)
   ) dut (
      .clk          (clk),
      .resetN       (resetN),
      .req          (req),
      .req_addr     (req_addr),
      .req_rw       (req_rw),
      .req_nbyte    (req_nbyte),
      .req_wdata    (req_wdata),
      .gnt          (gnt),
      .wr_next      (wr_next),
      .rd_valid     (rd_valid),
      .rd_data      (rd_data),
      .done         (done),
      .err          (err),
      .busy         (busy),
      .mst_en       (mst_en),
      .mst_resetN   (mst_resetN),
      .mst_address  (mst_address),
      .mst_rw       (mst_rw),
      .mst_N_byte   (mst_N_byte),
      .mst_data_in  (mst_data_in),
      .mst_data_out (mst_data_out),
      .mst_byte_stb (mst_byte_stb),
      .mst_done     (mst_done)
   );

   always #5 clk = ~clk;

   // Watchdog so a stuck DUT can never hang the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         errCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input int idx, input logic [6:0] addr, input logic rw, input logic [3:0] nb);
      req_addr[idx*7 +: 7]   = addr;
      req_rw[idx]            = rw;
      req_nbyte[idx*4 +: 4]  = nb;
      req                    = 4'b0;
      req[idx]               = 1'b1;
   endtask

   // Drives mst_done for one cycle and walks through the RECOVER window back to IDLE.
   task automatic finishTxn(input logic [3:0] expDone, input string tag);
      mst_done = 1'b1;
      tick();
      mst_done = 1'b0;
      checkOutput({tag, "_done"}, {28'b0, done}, {28'b0, expDone});
      repeat (RSTC) tick();
   endtask

   logic [3:0] rrExp [5];
   logic [7:0] rrData [5];
   int n;

   initial begin
      rrExp  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      rrData = '{8'hB0, 8'h11, 8'h22, 8'h33, 8'hB0};
      resetN       = 1'b0;
      req          = '0;
      req_addr     = '0;
      req_rw       = '0;
      req_nbyte    = '0;
      req_wdata    = {8'h33, 8'h22, 8'h11, 8'hB0};
      mst_data_out = '0;
      mst_byte_stb = 1'b0;
      mst_done     = 1'b0;
      tick();
      tick();
      checkOutput("rst_gnt", {28'b0, gnt}, 32'h0);
      checkOutput("rst_en_busy", {30'b0, mst_en, busy}, 32'h0);
      checkOutput("rst_mst_resetN", {31'b0, mst_resetN}, 32'h0);
      checkOutput("rst_pulses", {16'b0, wr_next, rd_valid, done, err}, 32'h0);
      resetN = 1'b1;
      tick();
      checkOutput("idle_mst_resetN", {31'b0, mst_resetN}, 32'h1);

      // Test 1: single write from requester 0
      applyStimulus(0, 7'h10, 1'b0, 4'd3);
      tick();
      req = '0;
      checkOutput("wr_grant", {28'b0, gnt}, 32'h1);
      checkOutput("wr_en", {31'b0, mst_en}, 32'h1);
      checkOutput("wr_cmd", {20'b0, mst_address, mst_rw, mst_N_byte}, {20'b0, 7'h10, 1'b0, 4'd3});
      checkOutput("wr_data_in", {24'b0, mst_data_in}, 32'hB0);
      for (int k = 0; k < 3; k++) begin
         mst_byte_stb = 1'b1;
         tick();
         mst_byte_stb = 1'b0;
         checkOutput($sformatf("wr_next_%0d", k), {28'b0, wr_next}, 32'h1);
         tick();
      end
      mst_done = 1'b1;
      tick();
      mst_done = 1'b0;
      checkOutput("wr_done", {28'b0, done}, 32'h1);
      checkOutput("wr_rec_en_gnt", {27'b0, mst_en, gnt}, 32'h0);
      repeat (RSTC - 1) tick();
      checkOutput("wr_rec_last_resetN", {31'b0, mst_resetN}, 32'h0);
      tick();
      checkOutput("wr_idle_resetN_busy", {30'b0, mst_resetN, busy}, 32'h2);
      checkOutput("idle_data_in", {24'b0, mst_data_in}, 32'h0);

      // Test 2: read from requester 1
      applyStimulus(1, 7'h22, 1'b1, 4'd2);
      tick();
      req = '0;
      checkOutput("rd_grant", {28'b0, gnt}, 32'h2);
      checkOutput("rd_rw", {31'b0, mst_rw}, 32'h1);
      mst_data_out = 8'hA5;
      mst_byte_stb = 1'b1;
      tick();
      mst_byte_stb = 1'b0;
      checkOutput("rd_valid_0", {20'b0, rd_valid, rd_data}, {20'b0, 4'b0010, 8'hA5});
      tick();
      mst_data_out = 8'h3C;
      mst_byte_stb = 1'b1;
      tick();
      mst_byte_stb = 1'b0;
      checkOutput("rd_valid_1", {20'b0, rd_valid, rd_data}, {20'b0, 4'b0010, 8'h3C});
      finishTxn(4'b0010, "rd");

      // Test 5a: address-only probe from requester 2, with a stray strobe
      applyStimulus(2, 7'h30, 1'b0, 4'd0);
      tick();
      req = '0;
      checkOutput("probe_grant", {28'b0, gnt}, 32'h4);
      mst_byte_stb = 1'b1;
      tick();
      mst_byte_stb = 1'b0;
      checkOutput("probe_no_wr_next", {28'b0, wr_next}, 32'h0);
      finishTxn(4'b0100, "probe");

      // Test 5b: same-cycle strobe and done on requester 3
      applyStimulus(3, 7'h31, 1'b0, 4'd2);
      tick();
      req = '0;
      checkOutput("same_grant", {28'b0, gnt}, 32'h8);
      mst_byte_stb = 1'b1;
      tick();
      checkOutput("same_wr_next_0", {28'b0, wr_next}, 32'h8);
      mst_done = 1'b1;
      tick();
      mst_byte_stb = 1'b0;
      mst_done     = 1'b0;
      checkOutput("same_both", {24'b0, wr_next, done}, {24'b0, 4'b1000, 4'b1000});
      repeat (RSTC) tick();

      // Test 4: timeout on requester 0, no strobes
      applyStimulus(0, 7'h40, 1'b0, 4'd1);
      tick();
      req = '0;
      checkOutput("to_grant", {28'b0, gnt}, 32'h1);
      n = 0;
      while (err == 4'b0 && n < 200) begin
         tick();
         n++;
      end
      checkOutput("to_cycle", n, 100);
      checkOutput("to_err_done", {24'b0, err, done}, {24'b0, 4'b0001, 4'b0000});
      checkOutput("to_recover", {30'b0, mst_resetN, busy}, 32'h1);
      repeat (RSTC) tick();

      // Test 6: reset during byte 2 of a write from requester 1
      applyStimulus(1, 7'h55, 1'b0, 4'd3);
      tick();
      req = '0;
      checkOutput("mid_grant", {28'b0, gnt}, 32'h2);
      mst_byte_stb = 1'b1;
      tick();
      checkOutput("mid_wr_next", {28'b0, wr_next}, 32'h2);
      resetN = 1'b0;
      tick();
      mst_byte_stb = 1'b0;
      checkOutput("mid_rst_outs", {16'b0, gnt, wr_next, done, err}, 32'h0);
      checkOutput("mid_rst_ctrl", {29'b0, mst_en, mst_resetN, busy}, 32'h0);
      checkOutput("mid_rst_addr", {25'b0, mst_address}, 32'h0);
      resetN = 1'b1;
      req    = 4'b1111;
      tick();
      checkOutput("mid_release_resetN", {31'b0, mst_resetN}, 32'h1);

      // Test 3: all requesters held, grants rotate starting at requester 0
      for (int g = 0; g < 5; g++) begin
         tick();
         checkOutput($sformatf("rr_grant_%0d", g), {28'b0, gnt}, {28'b0, rrExp[g]});
         checkOutput($sformatf("rr_data_%0d", g), {24'b0, mst_data_in}, {24'b0, rrData[g]});
         finishTxn(rrExp[g], $sformatf("rr_%0d", g));
      end
      req = '0;

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
